// File: rtl/pcpi_mm_pkg.sv
// Shared definitions for the PCPI matrix-multiply sequencer: opcode, funct3
// codes, bank address map, FSM/instruction-kind enums and instruction packing.
package pcpi_mm_pkg;

  localparam logic [6:0]  OPCODE      = 7'b0001011;
  localparam logic [2:0]  F_WRITE     = 3'b000;
  localparam logic [2:0]  F_CLEAR     = 3'b101;
  localparam logic [2:0]  F_START     = 3'b111;

  localparam int unsigned A_BASE      = 0;
  localparam int unsigned B_BASE      = 9;
  localparam int unsigned BIAS_BASE   = 18;
  localparam int unsigned THRESH_ADDR = 27;
  localparam int unsigned NUM_WORDS   = THRESH_ADDR + 1;

  localparam int unsigned IDX_W       = 5;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned INSN_W      = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_REQ,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_e;

  typedef enum logic [1:0] {
    K_WRITE,
    K_START,
    K_CLEAR
  } kind_e;

  // Coprocessor instruction word layout
  typedef struct packed {
    logic              rsvd;
    logic [DATA_W-1:0] value;
    logic [2:0]        funct3;
    logic [IDX_W-1:0]  index;
    logic [6:0]        opcode;
  } insn_t;

  function automatic logic [INSN_W-1:0] pack_insn(input logic [2:0]        funct3,
                                                  input logic [IDX_W-1:0]  index,
                                                  input logic [DATA_W-1:0] value);
    insn_t w;
    w.rsvd   = 1'b0;
    w.value  = value;
    w.funct3 = funct3;
    w.index  = index;
    w.opcode = OPCODE;
    return w;
  endfunction

endpackage

// File: rtl/pcpi_mm_sequencer_if.sv
// PCPI bus between the sequencer (master) and the coprocessor (slave).
//   pcpi_valid/pcpi_insn : instruction request from master
//   pcpi_wr/pcpi_rd      : responder write flag and result
//   pcpi_wait            : responder busy indication (informational)
//   pcpi_ready           : responder completion
interface pcpi_mm_sequencer_if;
  import pcpi_mm_pkg::*;

  logic              pcpi_valid;
  logic [INSN_W-1:0] pcpi_insn;
  logic              pcpi_wr;
  logic [INSN_W-1:0] pcpi_rd;
  logic              pcpi_wait;
  logic              pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/pcpi_word_bank.sv
// Staging bank: NUM_WORDS x 16-bit words plus a dirty bit per word.
//   we/waddr/wdata : host write, sets the word's dirty bit
//   clr/clr_idx    : clears one dirty bit after its write instruction completes
//   set_all        : marks every word dirty (reset)
//   raddr/rdata_c  : combinational read port
//   dirty          : dirty bitmap
module pcpi_word_bank
  import pcpi_mm_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 clr,
  input  logic [IDX_W-1:0]     clr_idx,
  input  logic                 set_all,
  input  logic [IDX_W-1:0]     raddr,
  output logic [DATA_W-1:0]    rdata_c,
  output logic [NUM_WORDS-1:0] dirty
);

  logic [DATA_W-1:0] mem [NUM_WORDS];

  // Word storage: no reset, contents are undefined until written
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Dirty bitmap; set_all dominates
  always_ff @(posedge clk) begin
    if (set_all) begin
      dirty <= '1;
    end else begin
      if (clr) dirty[clr_idx] <= 1'b0;
      if (we)  dirty[waddr]   <= 1'b1;
    end
  end

  assign rdata_c = (32'(raddr) < NUM_WORDS) ? mem[raddr] : '0;

endmodule

// File: rtl/pcpi_mm_sequencer.sv
// PCPI initiator that pushes changed bank words to the matrix-multiply
// coprocessor, starts it, captures the result and then clears it.
//   cfg_we/cfg_addr/cfg_data : host bank writes (ignored while busy)
//   go                       : start a run (accepted only when idle)
//   busy/done                : run in progress / one-cycle end-of-run pulse
//   err_timeout              : sticky, any instruction timed out this run
//   result/result_wr         : pcpi_rd/pcpi_wr captured at start completion
//   pcpi                     : PCPI master port
module pcpi_mm_sequencer
  import pcpi_mm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_addr,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic                go,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic [INSN_W-1:0]   result,
  output logic                result_wr,
  pcpi_mm_sequencer_if.master pcpi
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  kind_e                kind_q, kind_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 clear_sent_q, clear_sent_d;
  logic                 valid_d;
  logic [INSN_W-1:0]    insn_d;
  logic                 err_d;
  logic [INSN_W-1:0]    result_d;
  logic                 result_wr_d;
  logic                 bank_we_c;
  logic                 bank_clr_c;
  logic [DATA_W-1:0]    rdata_c;
  logic [NUM_WORDS-1:0] dirty;
  logic                 unused_wait;

  assign unused_wait = pcpi.pcpi_wait;

  // Host writes only land while idle and in range
  assign bank_we_c = cfg_we && (state_q == S_IDLE) && (32'(cfg_addr) < NUM_WORDS);

  pcpi_word_bank u_bank (
    .clk     (clk),
    .we      (bank_we_c),
    .waddr   (cfg_addr),
    .wdata   (cfg_data),
    .clr     (bank_clr_c),
    .clr_idx (idx_q),
    .set_all (!resetn),
    .raddr   (idx_q),
    .rdata_c (rdata_c),
    .dirty   (dirty)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    clear_sent_d = clear_sent_q;
    insn_d       = pcpi.pcpi_insn;
    err_d        = err_timeout;
    result_d     = result;
    result_wr_d  = result_wr;
    bank_clr_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          idx_d        = '0;
          err_d        = 1'b0;
          clear_sent_d = 1'b0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        if (32'(idx_q) == NUM_WORDS) begin
          kind_d  = K_START;
          insn_d  = pack_insn(F_START, '0, '0);
          state_d = S_REQ;
        end else if (dirty[idx_q]) begin
          kind_d  = K_WRITE;
          insn_d  = pack_insn(F_WRITE, idx_q, rdata_c);
          state_d = S_REQ;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_REQ: begin
        // pcpi_ready here belongs to the previous instruction
        cnt_d = '0;
        if (kind_q == K_CLEAR) clear_sent_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pcpi.pcpi_ready) begin
          if (kind_q == K_WRITE) begin
            bank_clr_c = 1'b1;
            idx_d      = idx_q + IDX_W'(1);
          end else if (kind_q == K_START) begin
            result_d    = pcpi.pcpi_rd;
            result_wr_d = pcpi.pcpi_wr;
          end
          state_d = S_GAP;
        end else if (32'(cnt_q) >= TIMEOUT - 1) begin
          // Abort: a timed-out write/start still gets a clear; a timed-out clear ends the run
          err_d = 1'b1;
          if (kind_q == K_CLEAR) begin
            state_d = S_FINISH;
          end else begin
            kind_d  = K_CLEAR;
            state_d = S_GAP;
          end
        end else if (32'(cnt_q) < TIMEOUT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (kind_q == K_WRITE) begin
          state_d = S_SCAN;
        end else if (kind_q == K_START || !clear_sent_q) begin
          kind_d  = K_CLEAR;
          insn_d  = pack_insn(F_CLEAR, '0, '0);
          state_d = S_REQ;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d = (state_d == S_REQ) || (state_d == S_WAIT);
    if (!valid_d) insn_d = '0;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      kind_q          <= K_WRITE;
      idx_q           <= '0;
      cnt_q           <= '0;
      clear_sent_q    <= 1'b0;
      pcpi.pcpi_valid <= 1'b0;
      pcpi.pcpi_insn  <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_timeout     <= 1'b0;
      result          <= '0;
      result_wr       <= 1'b0;
    end else begin
      state_q         <= state_d;
      kind_q          <= kind_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      clear_sent_q    <= clear_sent_d;
      pcpi.pcpi_valid <= valid_d;
      pcpi.pcpi_insn  <= insn_d;
      busy            <= (state_d != S_IDLE);
      done            <= (state_d == S_FINISH);
      err_timeout     <= err_d;
      result          <= result_d;
      result_wr       <= result_wr_d;
    end
  end

endmodule

// File: tb/tb_pcpi_mm_sequencer.sv
// Directed bench for pcpi_mm_sequencer with a small PCPI responder model.
module tb_pcpi_mm_sequencer;
  import pcpi_mm_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        go = 1'b0;
  logic        busy, done, err_timeout, result_wr;
  logic [31:0] result;

  always #5 clk = ~clk;

  pcpi_mm_sequencer_if pif ();

  pcpi_mm_sequencer #(.TIMEOUT(64)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .result      (result),
    .result_wr   (result_wr),
    .pcpi        (pif)
  );

  // Responder: mode 0 ready on first WAIT cycle, 1 ready always,
  // 2 like mode 0 but never readies a start instruction
  int          resp_mode = 0;
  logic        resp_prev_valid = 1'b0;
  logic [31:0] resp_rd = 32'hCAFE_0001;
  logic        resp_wr = 1'b0;

  always @(posedge clk) resp_prev_valid <= pif.pcpi_valid;

  always_comb begin
    pif.pcpi_rd = resp_rd;
    pif.pcpi_wr = resp_wr;
    case (resp_mode)
      1:       pif.pcpi_ready = 1'b1;
      2:       pif.pcpi_ready = pif.pcpi_valid && resp_prev_valid && (pif.pcpi_insn[14:12] != 3'b111);
      default: pif.pcpi_ready = pif.pcpi_valid && resp_prev_valid;
    endcase
    pif.pcpi_wait = pif.pcpi_valid && !pif.pcpi_ready;
  end

  // Monitor: logs each instruction and how many cycles valid stayed high
  logic [31:0] insn_log[$];
  int          len_log[$];
  int          busy_cycles = 0;
  int          done_cnt = 0;
  int          stab_bad = 0;
  logic        mon_prev_valid = 1'b0;
  logic [31:0] mon_prev_insn = '0;

  always @(negedge clk) begin
    if (pif.pcpi_valid && !mon_prev_valid) begin
      insn_log.push_back(pif.pcpi_insn);
      len_log.push_back(1);
    end else if (pif.pcpi_valid) begin
      len_log[len_log.size()-1] = len_log[len_log.size()-1] + 1;
      if (pif.pcpi_insn != mon_prev_insn) stab_bad++;
    end
    if (busy) busy_cycles++;
    if (done) done_cnt++;
    mon_prev_valid = pif.pcpi_valid;
    mon_prev_insn  = pif.pcpi_insn;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Pulse go (optionally with a same-cycle write), wait for the run to end.
  // inject: during the run, attempt a bank write to addr 3 and a second go.
  task automatic run(input string tag, input bit co_we, input logic [4:0] co_addr,
                     input logic [15:0] co_data, input bit inject,
                     output int first, output int ninsn, output int bcyc, output int dcnt);
    int b0, d0, s0, cyc;
    first = insn_log.size(); b0 = busy_cycles; d0 = done_cnt; s0 = stab_bad;
    go = 1'b1;
    if (co_we) begin cfg_we = 1'b1; cfg_addr = co_addr; cfg_data = co_data; end
    @(negedge clk);
    go = 1'b0; cfg_we = 1'b0;
    cyc = 0;
    while (busy && cyc < 3000) begin
      if (inject && cyc == 0) chk({tag, " err_cleared_by_go"}, 32'(err_timeout), 32'd0);
      if (inject && cyc == 3) begin
        cfg_we = 1'b1; cfg_addr = 5'd3; cfg_data = 16'h7777; go = 1'b1;
      end
      if (inject && cyc == 4) begin cfg_we = 1'b0; go = 1'b0; end
      @(negedge clk);
      cyc++;
    end
    chk({tag, " run_ended"}, 32'(busy), 32'd0);
    ninsn = insn_log.size() - first;
    bcyc  = busy_cycles - b0;
    dcnt  = done_cnt - d0;
    chk({tag, " insn_stable"}, 32'(stab_bad - s0), 32'd0);
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    logic [31:0] exp_insn;
  } vec_t;

  vec_t vt[28];

  initial begin
    int first, ninsn, bcyc, dcnt, cyc, sz;
    logic [15:0] d;

    // Bank image: A = identity, B = 2*identity, bias = 0, thresh = -70
    for (int i = 0; i < 28; i++) begin
      d = 16'h0000;
      if (i == 0 || i == 4 || i == 8)   d = 16'h0001;
      if (i == 9 || i == 13 || i == 17) d = 16'h0002;
      if (i == 27)                      d = 16'hFFBA;
      vt[i].addr     = 5'(i);
      vt[i].data     = d;
      vt[i].exp_insn = {1'b0, d, 3'b000, 5'(i), 7'b0001011};
    end

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst valid", 32'(pif.pcpi_valid), 32'd0);
    chk("rst insn", pif.pcpi_insn, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err_timeout), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst result_wr", 32'(result_wr), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Full load: 28 writes in index order, then start and clear
    for (int i = 0; i < 28; i++) wr(vt[i].addr, vt[i].data);
    run("full", 1'b0, '0, '0, 1'b0, first, ninsn, bcyc, dcnt);
    chk("full ninsn", 32'(ninsn), 32'd30);
    if (ninsn == 30) begin
      for (int i = 0; i < 28; i++) chk($sformatf("full write[%0d]", i), insn_log[first+i], vt[i].exp_insn);
      chk("full first_literal", insn_log[first], 32'h0000_800B);
      chk("full thresh_literal", insn_log[first+27], 32'h7FDD_0D8B);
      chk("full start", insn_log[first+28], 32'h0000_700B);
      chk("full clear", insn_log[first+29], 32'h0000_500B);
    end
    chk("full done_pulses", 32'(dcnt), 32'd1);
    chk("full err", 32'(err_timeout), 32'd0);
    chk("full busy_cycles", 32'(bcyc), 32'd120);
    chk("full result", result, 32'hCAFE_0001);
    chk("full result_wr", 32'(result_wr), 32'd0);

    // Only thresh changed (written in the go cycle); out-of-range write ignored
    wr(5'd30, 16'h1111);
    run("one", 1'b1, 5'd27, 16'd5, 1'b0, first, ninsn, bcyc, dcnt);
    chk("one ninsn", 32'(ninsn), 32'd3);
    if (ninsn == 3) begin
      chk("one write27", insn_log[first], 32'h0002_8D8B);
      chk("one start", insn_log[first+1], 32'h0000_700B);
      chk("one clear", insn_log[first+2], 32'h0000_500B);
    end
    // 29 SCAN + write(3) + start(3) + clear(3) + FINISH
    chk("one busy_cycles", 32'(bcyc), 32'd39);
    chk("one done_pulses", 32'(dcnt), 32'd1);

    // Responder always ready: each insn still takes REQ + 1 WAIT
    resp_mode = 1; resp_rd = 32'h1234_5678; resp_wr = 1'b1;
    wr(5'd0, 16'h0003);
    run("rdy", 1'b0, '0, '0, 1'b0, first, ninsn, bcyc, dcnt);
    chk("rdy ninsn", 32'(ninsn), 32'd3);
    if (ninsn == 3) begin
      chk("rdy write0", insn_log[first], 32'h0001_800B);
      for (int i = 0; i < 3; i++) chk($sformatf("rdy len[%0d]", i), 32'(len_log[first+i]), 32'd2);
    end
    chk("rdy result", result, 32'h1234_5678);
    chk("rdy result_wr", 32'(result_wr), 32'd1);

    // Start never readied: 64 WAIT cycles, then clear and done
    resp_mode = 2; resp_rd = 32'hDEAD_0000; resp_wr = 1'b0;
    wr(5'd5, 16'h0007);
    run("tmo", 1'b0, '0, '0, 1'b0, first, ninsn, bcyc, dcnt);
    chk("tmo ninsn", 32'(ninsn), 32'd3);
    if (ninsn == 3) begin
      chk("tmo write5", insn_log[first], 32'h0003_828B);
      chk("tmo start", insn_log[first+1], 32'h0000_700B);
      chk("tmo start_len", 32'(len_log[first+1]), 32'd65);
      chk("tmo clear", insn_log[first+2], 32'h0000_500B);
    end
    chk("tmo err", 32'(err_timeout), 32'd1);
    chk("tmo done_pulses", 32'(dcnt), 32'd1);
    chk("tmo busy_cycles", 32'(bcyc), 32'd102);
    chk("tmo result_kept", result, 32'h1234_5678);
    chk("tmo result_wr_kept", 32'(result_wr), 32'd1);

    // Next go clears err; write and go during busy are ignored
    resp_mode = 0;
    wr(5'd7, 16'h0009);
    run("bsy", 1'b0, '0, '0, 1'b1, first, ninsn, bcyc, dcnt);
    chk("bsy ninsn", 32'(ninsn), 32'd3);
    if (ninsn == 3) chk("bsy write7", insn_log[first], 32'h0004_838B);
    chk("bsy done_pulses", 32'(dcnt), 32'd1);
    chk("bsy busy_cycles", 32'(bcyc), 32'd39);
    chk("bsy err", 32'(err_timeout), 32'd0);
    sz = insn_log.size();
    repeat (6) @(negedge clk);
    chk("bsy no_second_run", 32'(busy), 32'd0);
    chk("bsy no_extra_insn", 32'(insn_log.size() - sz), 32'd0);
    run("cln", 1'b0, '0, '0, 1'b0, first, ninsn, bcyc, dcnt);
    chk("cln ninsn", 32'(ninsn), 32'd2);
    if (ninsn == 2) begin
      chk("cln start", insn_log[first], 32'h0000_700B);
      chk("cln clear", insn_log[first+1], 32'h0000_500B);
    end
    chk("cln busy_cycles", 32'(bcyc), 32'd36);

    // Reset while in WAIT on write index 10
    for (int i = 9; i < 13; i++) wr(5'(i), 16'(16'h0100 + i));
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cyc = 0;
    while (!(pif.pcpi_valid && resp_prev_valid && pif.pcpi_insn[11:7] == 5'd10) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid reach_wait10", 32'(cyc < 500), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid valid", 32'(pif.pcpi_valid), 32'd0);
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid result", result, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    run("rld", 1'b0, '0, '0, 1'b0, first, ninsn, bcyc, dcnt);
    chk("rld ninsn", 32'(ninsn), 32'd30);
    if (ninsn == 30) begin
      for (int i = 0; i < 28; i++)
        chk($sformatf("rld hdr[%0d]", i), insn_log[first+i] & 32'h0000_7FFF, 32'((i << 7) | 32'h0B));
    end
    chk("rld done_pulses", 32'(dcnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
